// File: rtl/adc_seg7_scanner.sv
// Four-digit multiplexed common-anode seven-segment scanner with frame-synchronous double buffering.
// Define SEG7_LEADING_ZERO_BLANK_EN to blank leading-zero digits.
module adc_seg7_scanner #(
  parameter int REFRESH_DIV = 100000,
  parameter int DIGITS      = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [4*DIGITS-1:0] data_in,
  input  logic                data_valid,
  input  logic [DIGITS-1:0]   dp_sel,
  input  logic                display_en,
  output logic [DIGITS-1:0]   anode,
  output logic [6:0]          cathode,
  output logic                dp,
  output logic                frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam logic [CW-1:0] DIV_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [CW-1:0]       r_div_cnt;
  logic [IW-1:0]       r_digit_idx;
  logic [4*DIGITS-1:0] r_pending;
  logic [4*DIGITS-1:0] r_disp;
  logic                r_pending_flag;
  logic [DIGITS-1:0]   r_anode;
  logic [6:0]          r_cathode;
  logic                r_dp;
  logic                r_frame_done;

  logic                w_tick;
  logic                w_frame_wrap;
  logic [3:0]          w_nib [DIGITS];
  logic [DIGITS-1:0]   w_blank;
  logic [3:0]          w_cur_nib;
  logic [6:0]          w_seg;

  assign w_tick       = (r_div_cnt == DIV_LAST);
  assign w_frame_wrap = w_tick && (r_digit_idx == IDX_LAST);

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_nib
      assign w_nib[gi] = r_disp[4*gi +: 4];
    end
  endgenerate

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // Blanking runs from the top digit down until a nonzero nibble or a lit decimal point.
  logic w_run;
  always_comb begin
    w_blank = '0;
    w_run   = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      w_run      = w_run && (w_nib[k] == 4'h0) && !dp_sel[k];
      w_blank[k] = w_run;
    end
  end
`else
  assign w_blank = '0;
`endif

  assign w_cur_nib = w_nib[r_digit_idx];

  always_comb begin
    w_seg = 7'h7F;
    case (w_cur_nib)
      4'h0: w_seg = 7'h40;
      4'h1: w_seg = 7'h79;
      4'h2: w_seg = 7'h24;
      4'h3: w_seg = 7'h30;
      4'h4: w_seg = 7'h19;
      4'h5: w_seg = 7'h12;
      4'h6: w_seg = 7'h02;
      4'h7: w_seg = 7'h78;
      4'h8: w_seg = 7'h00;
      4'h9: w_seg = 7'h10;
      4'hA: w_seg = 7'h08;
      4'hB: w_seg = 7'h03;
      4'hC: w_seg = 7'h46;
      4'hD: w_seg = 7'h21;
      4'hE: w_seg = 7'h06;
      4'hF: w_seg = 7'h0E;
      default: w_seg = 7'h7F;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_div_cnt   <= '0;
      r_digit_idx <= '0;
    end else begin
      r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
      if (w_tick) r_digit_idx <= r_digit_idx + 1'b1;
    end
  end

  // A strobe landing on the wrap edge goes straight to the display, superseding any pending word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pending      <= '0;
      r_disp         <= '0;
      r_pending_flag <= 1'b0;
      r_frame_done   <= 1'b0;
    end else begin
      r_frame_done <= w_frame_wrap;
      if (w_frame_wrap && data_valid) begin
        r_disp         <= data_in;
        r_pending      <= data_in;
        r_pending_flag <= 1'b0;
      end else if (w_frame_wrap && r_pending_flag) begin
        r_disp         <= r_pending;
        r_pending_flag <= 1'b0;
      end else if (data_valid) begin
        r_pending      <= data_in;
        r_pending_flag <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_anode   <= '1;
      r_cathode <= 7'h7F;
      r_dp      <= 1'b1;
    end else if (display_en && !w_blank[r_digit_idx]) begin
      r_anode   <= ~(DIGITS'(1) << r_digit_idx);
      r_cathode <= w_seg;
      r_dp      <= ~dp_sel[r_digit_idx];
    end else begin
      r_anode   <= '1;
      r_cathode <= 7'h7F;
      r_dp      <= 1'b1;
    end
  end

  assign anode      = r_anode;
  assign cathode    = r_cathode;
  assign dp         = r_dp;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_adc_seg7_scanner.sv
// Directed bench for adc_seg7_scanner with REFRESH_DIV=4; edge numbers in comments count posedges from time 0.
module tb_adc_seg7_scanner;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] data_in;
  logic        data_valid;
  logic [3:0]  dp_sel;
  logic        display_en;
  logic [3:0]  anode;
  logic [6:0]  cathode;
  logic        dp;
  logic        frame_done;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  adc_seg7_scanner #(.REFRESH_DIV(4), .DIGITS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .data_valid(data_valid),
    .dp_sel    (dp_sel),
    .display_en(display_en),
    .anode     (anode),
    .cathode   (cathode),
    .dp        (dp),
    .frame_done(frame_done)
  );

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] an, input logic [6:0] ca, input logic d);
    chk({tag, ".anode"}, 16'(anode), 16'(an));
    chk({tag, ".cathode"}, 16'(cathode), 16'(ca));
    chk({tag, ".dp"}, 16'(dp), 16'(d));
  endtask

  initial begin
    reset      = 1'b0;
    data_in    = 16'h0;
    data_valid = 1'b0;
    dp_sel     = 4'b1000;  // keeps all digits lit in the blanking build while the word is 0000
    display_en = 1'b1;

    cyc(1);
    chk_out("rst_during", 4'hF, 7'h7F, 1'b1);
    chk("rst_during.fd", 16'(frame_done), 16'h0);
    cyc(2);
    reset = 1'b1;
    chk_out("rst_release", 4'hF, 7'h7F, 1'b1);
    chk("rst_release.fd", 16'(frame_done), 16'h0);

    cyc(1);  // edge 4
    chk_out("scan_d0", 4'hE, 7'h40, 1'b1);
    cyc(3);  // edge 7
    chk("scan_d0_hold", 16'(anode), 16'hE);
    cyc(1);  // edge 8
    chk("scan_d1", 16'(anode), 16'hD);
    cyc(4);  // edge 12
    chk("scan_d2", 16'(anode), 16'hB);
    cyc(4);  // edge 16
    chk("scan_d3", 16'(anode), 16'h7);
    cyc(2);  // edge 18
    chk("fd_before", 16'(frame_done), 16'h0);
    cyc(1);  // edge 19: first wrap
    chk("fd_pulse", 16'(frame_done), 16'h1);
    cyc(1);  // edge 20
    chk("fd_after", 16'(frame_done), 16'h0);
    chk("scan_wrap", 16'(anode), 16'hE);

    data_in = 16'h1234; data_valid = 1'b1;
    cyc(1);  // edge 21: captured into pending
    data_valid = 1'b0; data_in = 16'h0;
    cyc(3);  // edge 24
    chk_out("pend_hold_d1", 4'hD, 7'h40, 1'b1);
    cyc(11); // edge 35
    chk("fd_frame2", 16'(frame_done), 16'h1);
    cyc(1);
    chk_out("x1234_d0", 4'hE, 7'h19, 1'b1);
    cyc(4);
    chk_out("x1234_d1", 4'hD, 7'h30, 1'b1);
    cyc(4);
    chk_out("x1234_d2", 4'hB, 7'h24, 1'b1);
    cyc(4);  // edge 48
    chk("x1234_d3.anode", 16'(anode), 16'h7);
    chk("x1234_d3.cathode", 16'(cathode), 16'h79);

    dp_sel = 4'b0000;
    data_in = 16'h1111; data_valid = 1'b1;
    cyc(1);  // edge 49
    data_valid = 1'b0;
    cyc(1);  // edge 50
    data_in = 16'hABCD; data_valid = 1'b1;
    cyc(1);  // edge 51: strobe coincides with wrap
    data_valid = 1'b0; data_in = 16'h0;
    chk("fd_frame3", 16'(frame_done), 16'h1);
    cyc(1);
    chk_out("xABCD_d0", 4'hE, 7'h21, 1'b1);
    cyc(4);
    chk_out("xABCD_d1", 4'hD, 7'h46, 1'b1);
    cyc(4);
    chk_out("xABCD_d2", 4'hB, 7'h03, 1'b1);
    cyc(4);  // edge 64
    chk_out("xABCD_d3", 4'h7, 7'h08, 1'b1);

    dp_sel = 4'b0100;
    cyc(4);  // edge 68
    chk_out("dp_d0", 4'hE, 7'h21, 1'b1);
    cyc(8);  // edge 76
    chk_out("dp_d2", 4'hB, 7'h03, 1'b0);
    display_en = 1'b0;
    cyc(1);  // edge 77
    chk_out("dis_d2", 4'hF, 7'h7F, 1'b1);
    cyc(6);  // edge 83
    chk_out("dis_d3", 4'hF, 7'h7F, 1'b1);
    chk("dis_fd", 16'(frame_done), 16'h1);
    display_en = 1'b1;
    cyc(1);  // edge 84
    chk_out("en_d0", 4'hE, 7'h21, 1'b1);
    cyc(8);  // edge 92
    chk_out("en_d2", 4'hB, 7'h03, 1'b0);

    dp_sel = 4'b0000;
    data_in = 16'h0005; data_valid = 1'b1;
    cyc(1);  // edge 93
    data_valid = 1'b0; data_in = 16'h0;
    cyc(6);  // edge 99
    chk("fd_0005", 16'(frame_done), 16'h1);
    cyc(1);
    chk_out("x0005_d0", 4'hE, 7'h12, 1'b1);
    cyc(4);
    chk_out("x0005_d1", BLANK ? 4'hF : 4'hD, BLANK ? 7'h7F : 7'h40, 1'b1);
    cyc(4);
    chk_out("x0005_d2", BLANK ? 4'hF : 4'hB, BLANK ? 7'h7F : 7'h40, 1'b1);
    cyc(4);  // edge 112
    chk_out("x0005_d3", BLANK ? 4'hF : 4'h7, BLANK ? 7'h7F : 7'h40, 1'b1);

    dp_sel = 4'b0010;
    data_in = 16'h0000; data_valid = 1'b1;
    cyc(1);  // edge 113
    data_valid = 1'b0;
    cyc(3);  // edge 116
    chk_out("x0000dp_d0", 4'hE, 7'h40, 1'b1);
    cyc(4);
    chk_out("x0000dp_d1", 4'hD, 7'h40, 1'b0);
    cyc(4);
    chk_out("x0000dp_d2", BLANK ? 4'hF : 4'hB, BLANK ? 7'h7F : 7'h40, 1'b1);
    cyc(4);  // edge 128
    chk_out("x0000dp_d3", BLANK ? 4'hF : 4'h7, BLANK ? 7'h7F : 7'h40, 1'b1);

    dp_sel = 4'b1000;
    data_in = 16'h9999; data_valid = 1'b1;
    cyc(1);  // edge 129
    data_valid = 1'b0; data_in = 16'h0;
    cyc(3);  // edge 132
    chk_out("x9999_d0", 4'hE, 7'h10, 1'b1);
    cyc(2);  // edge 134
    reset = 1'b0;
    cyc(1);  // edge 135
    chk_out("rst_mid", 4'hF, 7'h7F, 1'b1);
    chk("rst_mid.fd", 16'(frame_done), 16'h0);
    reset = 1'b1;
    cyc(1);  // edge 136
    chk_out("post_rst_d0", 4'hE, 7'h40, 1'b1);
    cyc(3);  // edge 139
    chk("post_rst_d0_hold", 16'(anode), 16'hE);
    cyc(1);  // edge 140
    chk_out("post_rst_d1", 4'hD, 7'h40, 1'b1);
    cyc(10); // edge 150
    chk("post_rst_fd_before", 16'(frame_done), 16'h0);
    cyc(1);  // edge 151
    chk("post_rst_fd", 16'(frame_done), 16'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_seg7_scanner.md
Name: adc_seg7_scanner

Overview:
- Downstream consumer of the ADC block's 16-bit output word (hex, BCD, raw or averaged, per the upstream format select).
- Drives a 4-digit multiplexed common-anode seven-segment display with per-nibble hex decode.
- Double-buffers the input so a digit pattern only changes at a frame boundary, which prevents tearing.
- Provides per-digit decimal-point control and display enable.

Parameters:
- REFRESH_DIV, 100000, clk cycles per digit slot; minimum 2; divider counter width is $clog2(REFRESH_DIV).
- DIGITS, 4, number of digits; fixed at 4, not to be overridden.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- data_in  input  16  word to display; nibble k drives digit k, with digit 0 the rightmost
- data_valid  input  1  single-cycle strobe; captures data_in
- dp_sel  input  4  decimal-point enable per digit, bit k = digit k, active-high
- display_en  input  1  0 = all anodes off; scanning continues
- anode  output  4  digit select, active-low, bit k = digit k
- cathode  output  7  segments {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point, active-low
- frame_done  output  1  one-cycle pulse at each frame wrap

Behaviour:
- Reset (reset=0 at a clk edge) clears:
  - div_cnt=0, digit_idx=0, pending_reg=0, disp_reg=0, pending_flag=0;
  - anode=4'hF, cathode=7'h7F, dp=1, frame_done=0.
- Reset asserted mid-frame aborts the frame; no partial update survives. The first cycle after release equals the reset state.
- Divider:
  - div_cnt counts 0..REFRESH_DIV-1 and then wraps to 0.
  - tick = (div_cnt==REFRESH_DIV-1).
  - On tick, digit_idx increments mod 4.
- Frame boundary: the tick cycle with digit_idx==3, i.e. the wrap 3->0. On that edge:
  - frame_done=1 for exactly one cycle;
  - if pending_flag=1, disp_reg<=pending_reg and pending_flag<=0.
- Capture: data_valid=1 -> pending_reg<=data_in, pending_flag<=1. Multiple strobes inside one frame: the last one wins.
- Simultaneous data_valid and frame boundary: data_in is loaded straight into disp_reg, pending_flag<=0, and the older pending value is discarded.
- Output pipeline: anode, cathode and dp are registered from digit_idx and disp_reg. Latency is 1 clk from a digit_idx change to the new anode and pattern.
  - anode = ~(1<<digit_idx) when display_en=1 and the digit is not blanked; otherwise 4'hF.
  - cathode = decode(disp_reg[4*digit_idx+:4]).
  - dp = ~dp_sel[digit_idx].
  - A blanked or disabled digit forces cathode=7'h7F and dp=1.
- display_en is sampled every cycle. It takes effect on the next registered output and does not reset the scan.
- Decode, active-low cathode {g..a}:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78;
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- No handshake back-pressure: the block always accepts data_valid.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined:
  - Scanning from digit 3 downward, a digit is blanked while its nibble and all more-significant nibbles are 0.
  - Digit 0 is never blanked.
  - A digit with dp_sel=1 is never blanked and stops blanking for the digits below it.
  - Blanked means anode stays 1 for that slot.
- Undefined: all four digits are always shown, including leading zeros. dp_sel still applies.

Test Plan:
- REFRESH_DIV=4, reset held low 3 cycles, then released:
  - anode=F, cathode=7F, dp=1, frame_done=0 during and 1 cycle after reset;
  - then anode cycles E,D,B,7, changing every 4 clks;
  - frame_done pulses once every 16 clks.
- data_valid with data_in=16'h1234 mid-frame -> the display keeps 0000 until the wrap, then shows:
  - digit0 cathode=19 ("4"), digit1=30, digit2=24, digit3=79.
- data_valid with 16'hABCD in the same cycle as the frame boundary -> the next frame shows D,C,b,A (21,46,03,08). An earlier pending 16'h1111 is never displayed.
- dp_sel=4'b0100, display_en toggled 1->0->1 -> dp=0 only in the digit2 slot; all anodes are F while disabled; digit_idx sequence is unbroken.
- With SEG7_LEADING_ZERO_BLANK_EN defined:
  - data=16'h0005 -> only anode E is ever asserted, digit0 cathode=12;
  - data=16'h0000, dp_sel=0010 -> digits 1 and 0 are shown, digits 3 and 2 are blanked;
  - with the macro undefined, all four anodes are active.
- reset pulsed low for 1 cycle mid-frame after loading 16'h9999 -> disp_reg=0, digit_idx=0, div_cnt=0; the display shows 0000 (cathode=40) after release.
